ibex_if_id_queue: RTL and testbench
===================================

# ibex_if_id_queue

Parametrised IF-ID instruction queue replacing the single-entry IF-ID pipeline register between the fetch path (prefetch buffer or icache, compressed decoder, dummy-instruction mux) and the ID stage. Buffers up to `Depth` decoded fetch entries, so a fetch burst is absorbed while ID stalls. Flushes on a PC change. Optionally bypasses an empty queue combinationally. Stops accepting entries after a fetch error until the next flush.

## Interface
- `Depth`, 2, number of entries; legal range 1..8.
- `FallThrough`, 1'b0, 1: an empty queue presents the input combinationally; 0: every entry is registered before it is presented.
- `CntW`, `$clog2(Depth+1)`, derived occupancy width; do not override.

Ports:
- `clk_i`  in  1  clock; all state is updated on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `in_valid_i`  in  1  the fetch entry is valid.
- `in_ready_o`  out  1  the queue accepts an entry this cycle.
- `in_instr_i`  in  32  decompressed or dummy instruction.
- `in_instr_c_i`  in  16  raw compressed bits, used for mtval.
- `in_is_compressed_i`, `in_illegal_c_i`, `in_err_i`, `in_err_plus2_i`, `in_dummy_i`  in  1 each  per-entry flags.
- `in_pc_i`  in  32  PC of the entry.
- `flush_i`  in  1  squash all entries (driven by pc_set).
- `out_valid_o`  out  1  the head entry is valid.
- `out_ready_i`  in  1  ID consumes the head this cycle.
- `out_new_o`  out  1  first cycle this head is presented (used for RVFI).
- `out_instr_o`, `out_instr_alu_o`  out  32  head instruction; the second output is a fan-out replica.
- `out_instr_c_o`  out  16; `out_is_compressed_o`, `out_illegal_c_o`, `out_err_o`, `out_err_plus2_o`, `out_dummy_o`  out  1 each; `out_pc_o`  out  32  head payload.
- `occupancy_o`  out  CntW  number of stored entries; excludes the bypass.

## Operation
- The queue is a circular buffer with `wr_ptr`, `rd_ptr` and `count`.
- Pointers wrap from Depth-1 to 0. Depth need not be a power of two.
- Payload storage is not reset. Only the control state (pointers, `count`, `err_stop_q`, `head_seen_q`) is reset.

Acceptance:
- `in_ready_o = (count != Depth) & ~err_stop_q`.
- There is no combinational path from `out_ready_i` to `in_ready_o`. A full queue does not accept an entry even when a pop happens in the same cycle.
- push = `in_valid_i & in_ready_o & ~flush_i & ~bypass_take`.
- pop = `out_valid_o & out_ready_i & ~flush_i & (count != 0)`.
- A simultaneous push and pop leaves `count` unchanged; both pointers advance.

Bypass (FallThrough=1 only):
- When `count == 0`, `out_valid_o = in_valid_i & ~err_stop_q & ~flush_i` and the payload comes from the inputs.
- `bypass_take` = bypass active & `out_ready_i`; the entry is then not written to storage.
- With FallThrough=0, `out_valid_o = (count != 0)`.

Flush:
- `flush_i` is highest priority. On the next edge: `count` = 0, both pointers = 0, `err_stop_q` = 0, `head_seen_q` = 0.
- Any same-cycle push or pop is discarded.
- With FallThrough=1 the bypass is masked in the flush cycle.

Error stop:
- `err_stop_q` sets on the edge where an entry with `in_err_i = 1` is pushed or bypass-taken.
- While set, `in_ready_o = 0` and the bypass is disabled.
- Entries already stored still drain normally.
- Only `flush_i` or reset clears it.

New flag:
- `out_new_o = out_valid_o & ~head_seen_q`.
- `head_seen_q` sets when `out_valid_o & ~out_ready_i`.
- It clears on pop, bypass_take or flush. Each entry therefore asserts `out_new_o` exactly once, in the first cycle it is presented.

Data outputs are don't-care while `out_valid_o = 0`.

## Timing
Reset: state takes its reset values on the edge where `rst_i` = 1. From the following cycle:
- `out_valid_o` = 0, `out_new_o` = 0, `occupancy_o` = 0.
- `in_ready_o` = 1, and with FallThrough=1 the bypass is enabled.
- Reset asserted mid-operation discards all entries, exactly like a flush.

Latency:
- FallThrough=0: an entry pushed at edge N appears on `out_*` in cycle N+1.
- FallThrough=1 with the queue empty: the entry appears in the same cycle (0 cycles).
- Throughput is 1 entry per cycle sustained, provided `count < Depth`.

Full:
- A full queue with a pop in cycle N has `in_ready_o` = 1 from cycle N+1.

Depth=1:
- Behaves as a single register.
- With FallThrough=0, sustained throughput is 1 entry every 2 cycles.

Output timing:
- `out_*` payload and `out_valid_o` are driven from registers when FallThrough=0.

## Test plan
- **Registered fill.** FallThrough=0, Depth=2, `out_ready_i` = 0. Push PC 0x80, then 0x84, then offer 0x88.
  - `occupancy_o` goes 1 → 2.
  - `in_ready_o` = 0 in the cycle 0x88 is offered.
  - Head PC = 0x80 with `out_new_o` high for exactly 1 cycle.
- **Drain and ordering.** From the full state, `out_ready_i` = 1 for 3 cycles.
  - Pops 0x80 then 0x84; `out_valid_o` = 0 in the third cycle.
  - `out_new_o` is high on each new head.
  - The pointers wrap correctly; refill with 0x88/0x8C keeps order.
- **Flush with simultaneous push and pop.** 2 entries stored; in one cycle `flush_i` = 1, `in_valid_i` = 1 (PC 0x200), `out_ready_i` = 1.
  - Next cycle `occupancy_o` = 0 and `out_valid_o` = 0.
  - 0x200 is never presented.
- **Bypass.** FallThrough=1, queue empty; `in_valid_i` with PC 0x100 and `out_ready_i` = 1.
  - Same cycle: `out_pc_o` = 0x100, `out_valid_o` = 1, `out_new_o` = 1.
  - `occupancy_o` stays 0.
  - The same stimulus with `flush_i` = 1 gives `out_valid_o` = 0.
- **Error stop.** Push PC 0x40 with `in_err_i` = 1.
  - `in_ready_o` = 0 from the next cycle; the entry still drains with `out_err_o` = 1.
  - `in_ready_o` returns to 1 one cycle after `flush_i`.
- **Reset mid-burst.** Depth=4 holding 3 entries; pulse `rst_i` for 1 cycle.
  - Next cycle: `occupancy_o` = 0, `out_valid_o` = 0, `in_ready_o` = 1.

Source files
------------

// File: rtl/ibex_if_id_queue.sv
// IF-ID instruction queue: a small circular buffer of decoded fetch entries
// between the fetch path and the ID stage. It absorbs fetch bursts while ID
// stalls, squashes everything on flush, can bypass an empty queue, and stops
// accepting new entries after a fetch error until the next flush.
module ibex_if_id_queue #(
  parameter int unsigned Depth       = 2,
  parameter bit          FallThrough = 1'b0,
  parameter int unsigned CntW        = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [15:0]     in_instr_c_i,
  input  logic            in_is_compressed_i,
  input  logic            in_illegal_c_i,
  input  logic            in_err_i,
  input  logic            in_err_plus2_i,
  input  logic            in_dummy_i,
  input  logic [31:0]     in_pc_i,

  input  logic            flush_i,

  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            out_new_o,
  output logic [31:0]     out_instr_o,
  output logic [31:0]     out_instr_alu_o,
  output logic [15:0]     out_instr_c_o,
  output logic            out_is_compressed_o,
  output logic            out_illegal_c_o,
  output logic            out_err_o,
  output logic            out_err_plus2_o,
  output logic            out_dummy_o,
  output logic [31:0]     out_pc_o,

  output logic [CntW-1:0] occupancy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [15:0] instr_c;
    logic        is_compressed;
    logic        illegal_c;
    logic        err;
    logic        err_plus2;
    logic        dummy;
    logic [31:0] pc;
  } entry_t;

  entry_t          mem_q [Depth];
  entry_t          in_entry;
  entry_t          head_entry;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_stop_q, err_stop_d;
  logic            head_seen_q, head_seen_d;

  logic            empty, full;
  logic            bypass_valid, bypass_take;
  logic            push, pop;

  // Pointers wrap explicitly so Depth need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  assign in_entry = '{instr:         in_instr_i,
                      instr_c:       in_instr_c_i,
                      is_compressed: in_is_compressed_i,
                      illegal_c:     in_illegal_c_i,
                      err:           in_err_i,
                      err_plus2:     in_err_plus2_i,
                      dummy:         in_dummy_i,
                      pc:            in_pc_i};

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(Depth));

  // in_ready deliberately ignores out_ready_i: no combinational path from ID.
  assign in_ready_o = ~full & ~err_stop_q;

  // Bypass only exists with FallThrough; it is masked by flush and error stop.
  assign bypass_valid = FallThrough & empty & in_valid_i & ~err_stop_q & ~flush_i;
  assign bypass_take  = bypass_valid & out_ready_i;

  assign out_valid_o = ~empty | bypass_valid;
  assign out_new_o   = out_valid_o & ~head_seen_q;

  assign push = in_valid_i & in_ready_o & ~flush_i & ~bypass_take;
  assign pop  = out_valid_o & out_ready_i & ~flush_i & ~empty;

  // Head payload: inputs when bypassing an empty queue, else the stored head.
  always_comb begin
    head_entry = mem_q[rd_ptr_q];
    if (FallThrough && empty) head_entry = in_entry;
  end

  assign out_instr_o         = head_entry.instr;
  assign out_instr_alu_o     = head_entry.instr;
  assign out_instr_c_o       = head_entry.instr_c;
  assign out_is_compressed_o = head_entry.is_compressed;
  assign out_illegal_c_o     = head_entry.illegal_c;
  assign out_err_o           = head_entry.err;
  assign out_err_plus2_o     = head_entry.err_plus2;
  assign out_dummy_o         = head_entry.dummy;
  assign out_pc_o            = head_entry.pc;
  assign occupancy_o         = count_q;

  // Next-state for pointers, count, error stop and new-head tracking.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_stop_d  = err_stop_q;
    head_seen_d = head_seen_q;

    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      err_stop_d  = 1'b0;
      head_seen_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (!push && pop) count_d = count_q - CntW'(1);

      if ((push || bypass_take) && in_err_i) err_stop_d = 1'b1;

      if (pop || bypass_take)             head_seen_d = 1'b0;
      else if (out_valid_o && !out_ready_i) head_seen_d = 1'b1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_stop_q  <= 1'b0;
      head_seen_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_stop_q  <= err_stop_d;
      head_seen_q <= head_seen_d;
    end
  end

  // Payload storage write on push.
  always_ff @(posedge clk_i) begin
    // NOTE: payload is not reset; count_q qualifies it, so stale data is never presented.
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

endmodule

// File: tb/tb_ibex_if_id_queue.sv
// Testbench for ibex_if_id_queue: three instances (Depth2/registered,
// Depth2/fall-through, Depth4/registered) share one stimulus stream. A
// table drives the fill/drain sequence, short directed sequences cover
// flush, bypass, error stop and reset, and a random phase compares every
// instance with a queue-based reference model.
module tb_ibex_if_id_queue;

  typedef struct packed {
    logic [31:0] instr;
    logic [15:0] instr_c;
    logic        is_c;
    logic        ill_c;
    logic        err;
    logic        err_p2;
    logic        dummy;
    logic [31:0] pc;
  } ent_t;

  typedef struct packed {
    logic        in_ready;
    logic        out_valid;
    logic        out_new;
    logic [3:0]  occ;
    ent_t        head;
    logic [31:0] instr_alu;
  } obs_t;

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic        e_new;
    logic [3:0]  e_occ;
    logic [31:0] e_pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic flush;
  logic out_ready;
  ent_t drv;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned D  = (g == 2) ? 4 : 2;
    localparam bit          FT = (g == 1);
    localparam int unsigned CW = $clog2(D + 1);

    logic          in_ready, out_valid, out_new;
    logic [31:0]   instr, instr_alu, pc;
    logic [15:0]   instr_c;
    logic          is_c, ill_c, err, err_p2, dummy;
    logic [CW-1:0] occ;
    obs_t          o;

    ibex_if_id_queue #(.Depth(D), .FallThrough(FT)) u_dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .in_valid_i         (in_valid),
      .in_ready_o         (in_ready),
      .in_instr_i         (drv.instr),
      .in_instr_c_i       (drv.instr_c),
      .in_is_compressed_i (drv.is_c),
      .in_illegal_c_i     (drv.ill_c),
      .in_err_i           (drv.err),
      .in_err_plus2_i     (drv.err_p2),
      .in_dummy_i         (drv.dummy),
      .in_pc_i            (drv.pc),
      .flush_i            (flush),
      .out_valid_o        (out_valid),
      .out_ready_i        (out_ready),
      .out_new_o          (out_new),
      .out_instr_o        (instr),
      .out_instr_alu_o    (instr_alu),
      .out_instr_c_o      (instr_c),
      .out_is_compressed_o(is_c),
      .out_illegal_c_o    (ill_c),
      .out_err_o          (err),
      .out_err_plus2_o    (err_p2),
      .out_dummy_o        (dummy),
      .out_pc_o           (pc),
      .occupancy_o        (occ)
    );

    assign o = {in_ready, out_valid, out_new, 4'(occ),
                instr, instr_c, is_c, ill_c, err, err_p2, dummy, pc, instr_alu};
  end

  function automatic obs_t get_obs(input int g);
    case (g)
      0:       return g_dut[0].o;
      1:       return g_dut[1].o;
      default: return g_dut[2].o;
    endcase
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic vld, input logic [31:0] pc, input logic err,
                        input logic fl, input logic ordy);
    in_valid    = vld;
    drv.pc      = pc;
    drv.instr   = {pc[15:0], ~pc[15:0]};
    drv.instr_c = pc[15:0] ^ 16'h5a5a;
    drv.is_c    = 1'b0;
    drv.ill_c   = 1'b0;
    drv.err     = err;
    drv.err_p2  = 1'b0;
    drv.dummy   = 1'b0;
    flush       = fl;
    out_ready   = ordy;
  endtask

  // Reset all instances over one rising edge; returns just after a falling edge.
  task automatic do_reset();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: one queue of entries per instance plus two flags.
  localparam int DEP [3] = '{2, 2, 4};
  localparam bit FTS [3] = '{1'b0, 1'b1, 1'b0};
  ent_t mq [3][$];
  bit   m_err [3];
  bit   m_seen [3];

  task automatic model_clear();
    for (int g = 0; g < 3; g++) begin
      mq[g].delete();
      m_err[g]  = 1'b0;
      m_seen[g] = 1'b0;
    end
  endtask

  // Compare one instance with the model for the current inputs, then advance the model.
  task automatic model_step(input int g, input int cyc);
    obs_t o;
    int   cnt;
    bit   e_ir, e_ov, e_new, take;
    ent_t head;
    o     = get_obs(g);
    cnt   = mq[g].size();
    e_ir  = (cnt < DEP[g]) && !m_err[g];
    e_ov  = (cnt > 0) || (FTS[g] && in_valid && !m_err[g] && !flush);
    e_new = e_ov && !m_seen[g];
    head  = (cnt > 0) ? mq[g][0] : drv;

    check($sformatf("rnd%0d u%0d in_ready", cyc, g), 96'(o.in_ready), 96'(e_ir));
    check($sformatf("rnd%0d u%0d out_valid", cyc, g), 96'(o.out_valid), 96'(e_ov));
    check($sformatf("rnd%0d u%0d out_new", cyc, g), 96'(o.out_new), 96'(e_new));
    check($sformatf("rnd%0d u%0d occupancy", cyc, g), 96'(o.occ), 96'(cnt));
    if (e_ov) begin
      check($sformatf("rnd%0d u%0d head", cyc, g), 96'(o.head), 96'(head));
      check($sformatf("rnd%0d u%0d instr_alu", cyc, g), 96'(o.instr_alu), 96'(head.instr));
    end

    if (flush) begin
      mq[g].delete();
      m_err[g]  = 1'b0;
      m_seen[g] = 1'b0;
    end else begin
      take = e_ov && out_ready;
      if (cnt == 0 && take) begin
        if (drv.err) m_err[g] = 1'b1;
        m_seen[g] = 1'b0;
      end else begin
        if (take) begin
          void'(mq[g].pop_front());
          m_seen[g] = 1'b0;
        end else if (e_ov) begin
          m_seen[g] = 1'b1;
        end
        if (in_valid && e_ir) begin
          mq[g].push_back(drv);
          if (drv.err) m_err[g] = 1'b1;
        end
      end
    end
  endtask

  vec_t tbl [17];

  initial begin
    obs_t o;
    rst = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    //             vld  pc     ordy ir  ov  new occ e_pc
    tbl[0]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h00};
    tbl[1]  = '{1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h00};
    tbl[2]  = '{1'b1, 32'h84, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 32'h80};
    tbl[3]  = '{1'b1, 32'h88, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 32'h80};
    tbl[4]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 32'h80};
    tbl[5]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 32'h84};
    tbl[6]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h00};
    tbl[7]  = '{1'b1, 32'h88, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h00};
    tbl[8]  = '{1'b1, 32'h8C, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 32'h88};
    tbl[9]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 32'h88};
    tbl[10] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 32'h8C};
    tbl[11] = '{1'b1, 32'h90, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h00};
    tbl[12] = '{1'b1, 32'h94, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 32'h90};
    tbl[13] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 32'h94};
    tbl[14] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 32'h94};
    tbl[15] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 32'h94};
    tbl[16] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h00};

    @(negedge clk);
    do_reset();

    // Registered fill, drain, wrap and refill on the Depth=2 registered instance.
    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].vld, tbl[i].pc, 1'b0, 1'b0, tbl[i].ordy);
      #1;
      o = get_obs(0);
      check($sformatf("tbl%0d in_ready", i), 96'(o.in_ready), 96'(tbl[i].e_ir));
      check($sformatf("tbl%0d out_valid", i), 96'(o.out_valid), 96'(tbl[i].e_ov));
      check($sformatf("tbl%0d out_new", i), 96'(o.out_new), 96'(tbl[i].e_new));
      check($sformatf("tbl%0d occupancy", i), 96'(o.occ), 96'(tbl[i].e_occ));
      if (tbl[i].e_ov)
        check($sformatf("tbl%0d pc", i), 96'(o.head.pc), 96'(tbl[i].e_pc));
      @(negedge clk);
    end

    // Flush with simultaneous push and pop.
    do_reset();
    set_in(1'b1, 32'hA0, 1'b0, 1'b0, 1'b0); @(negedge clk);
    set_in(1'b1, 32'hA4, 1'b0, 1'b0, 1'b0); @(negedge clk);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); #1;
    check("flush pre occupancy", 96'(get_obs(0).occ), 96'd2);
    @(negedge clk);
    set_in(1'b1, 32'h200, 1'b0, 1'b1, 1'b1); @(negedge clk);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1); #1;
    check("flush occupancy", 96'(get_obs(0).occ), 96'd0);
    check("flush out_valid", 96'(get_obs(0).out_valid), 96'd0);
    @(negedge clk); #1;
    check("flush 0x200 not presented", 96'(get_obs(0).out_valid), 96'd0);
    @(negedge clk);

    // Bypass on the fall-through instance.
    do_reset();
    set_in(1'b1, 32'h100, 1'b0, 1'b0, 1'b1); #1;
    o = get_obs(1);
    check("bypass out_valid", 96'(o.out_valid), 96'd1);
    check("bypass out_new", 96'(o.out_new), 96'd1);
    check("bypass pc", 96'(o.head.pc), 96'h100);
    check("bypass occupancy", 96'(o.occ), 96'd0);
    @(negedge clk);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1); #1;
    check("bypass after occupancy", 96'(get_obs(1).occ), 96'd0);
    check("bypass after out_valid", 96'(get_obs(1).out_valid), 96'd0);
    @(negedge clk);
    set_in(1'b1, 32'h100, 1'b0, 1'b1, 1'b1); #1;
    check("bypass flush out_valid", 96'(get_obs(1).out_valid), 96'd0);
    @(negedge clk);
    set_in(1'b1, 32'h104, 1'b0, 1'b0, 1'b0); #1;
    check("bypass stall out_new", 96'(get_obs(1).out_new), 96'd1);
    @(negedge clk);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); #1;
    o = get_obs(1);
    check("bypass stored occupancy", 96'(o.occ), 96'd1);
    check("bypass stored out_new", 96'(o.out_new), 96'd0);
    check("bypass stored pc", 96'(o.head.pc), 96'h104);
    @(negedge clk);

    // Error stop.
    do_reset();
    set_in(1'b1, 32'h40, 1'b1, 1'b0, 1'b0); #1;
    check("err in_ready before", 96'(get_obs(0).in_ready), 96'd1);
    @(negedge clk);
    set_in(1'b1, 32'h44, 1'b0, 1'b0, 1'b1); #1;
    o = get_obs(0);
    check("err in_ready", 96'(o.in_ready), 96'd0);
    check("err out_valid", 96'(o.out_valid), 96'd1);
    check("err out_err", 96'(o.head.err), 96'd1);
    check("err pc", 96'(o.head.pc), 96'h40);
    @(negedge clk);
    set_in(1'b1, 32'h48, 1'b0, 1'b0, 1'b1); #1;
    check("err drained out_valid", 96'(get_obs(0).out_valid), 96'd0);
    check("err drained in_ready", 96'(get_obs(0).in_ready), 96'd0);
    check("err bypass blocked", 96'(get_obs(1).out_valid), 96'd0);
    @(negedge clk);
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b0); @(negedge clk);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); #1;
    check("err cleared in_ready", 96'(get_obs(0).in_ready), 96'd1);
    @(negedge clk);

    // Reset mid-burst on the Depth=4 instance.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    set_in(1'b1, 32'h30C, 1'b0, 1'b0, 1'b0); #1;
    check("rst pre occupancy", 96'(get_obs(2).occ), 96'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); #1;
    o = get_obs(2);
    check("rst occupancy", 96'(o.occ), 96'd0);
    check("rst out_valid", 96'(o.out_valid), 96'd0);
    check("rst in_ready", 96'(o.in_ready), 96'd1);
    @(negedge clk);

    // Random traffic against the reference model on all instances.
    do_reset();
    model_clear();
    for (int c = 0; c < 600; c++) begin
      in_valid    = ($urandom_range(3) != 0);
      drv.instr   = $urandom;
      drv.instr_c = 16'($urandom);
      drv.is_c    = 1'($urandom);
      drv.ill_c   = 1'($urandom);
      drv.err     = ($urandom_range(31) == 0);
      drv.err_p2  = 1'($urandom);
      drv.dummy   = 1'($urandom);
      drv.pc      = $urandom;
      flush       = ($urandom_range(15) == 0);
      out_ready   = ($urandom_range(2) != 0);
      #1;
      for (int g = 0; g < 3; g++) model_step(g, c);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
